tetris_renderer: RTL and testbench
==================================

// Module: tetris_renderer
// PURPOSE
// Parametrised pixel pipeline between vga_sync_reg and the two sprite/background SRAMs.
// Per pixel it decodes the playfield cell, score digit or background region, then generates the SRAM addresses.
// It composites the SRAM outputs with a transparency key and drives the registered RGB.
// Compared with the previous display block, it adds:
//   - generic board geometry, scale and digit count;
//   - a fixed, aligned 3-stage pipeline;
//   - row-flash animation for cleared lines, driven by a frame counter.
// PARAMETERS
// BOARD_X0     220     screen x of playfield left edge
// BOARD_Y0     40      screen y of playfield top edge
// BOARD_W      10      playfield columns
// BOARD_H      20      playfield rows
// CELL_PX      20      screen pixels per cell side; the cell sprite is CELL_PX/SCALE pixels per side
// SCALE        2       sprite/background upscale factor (power of 2)
// NUM_DIGITS   4       BCD score digits; digit 0 is the most significant and is drawn leftmost
// DIG_X0,DIG_Y0 128,450 screen origin of digit 0
// DIG_W,DIG_H  5,9     digit sprite size in sprite pixels
// DIG_GAP      2       sprite pixels between adjacent digits
// BG_W         320     background image width in sprite pixels
// KEY          12'hFFF transparent colour in the sprite SRAM
// FLASH_COLOR  12'hEEE colour used for flashing rows
// BLINK_LOG2   3       flash half-period is 2**BLINK_LOG2 frames
// PORTS
// clk          in   1                clock
// reset        in   1                synchronous, active-high reset
// p_tick       in   1                pixel strobe from vga_sync_reg
// visible      in   1                active-video flag
// pixel_x      in   10               current pixel x
// pixel_y      in   10               current pixel y
// cell_x       out  5                playfield column query; 0 outside the board
// cell_y       out  5                playfield row query; 0 outside the board
// cell_kind    in   4                kind of the queried cell; valid 1 clk after cell_x/cell_y
// score        in   4*NUM_DIGITS     BCD score; digit 0 occupies the top nibble
// flash_rows   in   BOARD_H          1 = this row flashes
// sprite_addr  out  18               sprite SRAM address; SRAM read latency is 1 clk
// sprite_data  in   12               sprite SRAM read data
// bg_addr      out  17               background SRAM address; read latency is 1 clk
// bg_data      in   12               background SRAM read data
// rgb          out  12               {R,G,B} to the VGA pins
// BEHAVIOUR
// - Reset values:
//   - cell_x, cell_y, bg_addr, rgb = 0;
//   - sprite_addr = T_ADDR;
//   - frame counter = 0;
//   - all pipeline valid/flag registers = 0.
// - Reset applied mid-frame: rgb = 0 on the next clk; frame counter restarts from 0.
// - Sprite SRAM layout (S = CELL_PX/SCALE):
//   - block k (1..7) starts at (k-1)*S*S;
//   - digit d starts at 7*S*S + d*DIG_W*DIG_H;
//   - T_ADDR = 7*S*S + 10*DIG_W*DIG_H holds KEY.
// - S1 (clk after pixel_x/pixel_y), registered:
//   - cell_x/cell_y = (p - origin)/CELL_PX;
//   - cell offsets = (p - origin)%CELL_PX;
//   - region flags (board, digit i) and the digit offsets.
//   - Digit i spans x in [DIG_X0 + i*(DIG_W+DIG_GAP)*SCALE, + DIG_W*SCALE), y in [DIG_Y0, DIG_Y0 + DIG_H*SCALE).
// - S2, registered:
//   - Board region, kind 1..7: sprite_addr = base + (oy/SCALE)*S + ox/SCALE.
//   - Board region, kind 0 or 8..15: sprite_addr = T_ADDR.
//   - Digit region, BCD value <= 9: digit base + offset. A BCD nibble > 9 gives T_ADDR (blank).
//   - Otherwise: sprite_addr = T_ADDR.
//   - bg_addr = (pixel_y/SCALE)*BG_W + pixel_x/SCALE, delayed to the same stage.
// - S3, combinational rgb_next, priority order:
//   1. visible=0 (delayed) gives 0;
//   2. board cell in a flash row with phase=1 and kind 1..7 gives FLASH_COLOR;
//   3. sprite_data != KEY gives sprite_data;
//   4. otherwise bg_data.
// - rgb <= rgb_next only on p_tick.
// - Latency from pixel_x/pixel_y to a valid rgb_next is exactly 3 clk. The p_tick spacing must be >= 4 clk.
// - visible, the region flags and the flash row bit are delayed through matching stages.
// - Frame counter:
//   - width BLINK_LOG2+1 bits; increments on p_tick when pixel_x==0 && pixel_y==0;
//   - wraps to 0;
//   - phase = MSB.
// - Arithmetic: all coordinate subtractions are evaluated only inside their region, so there is no wrap.
// - Overlapping regions: board has priority over digits.
// TESTING
// T1 pixel (220,40), cell_kind=3 -> cell_x=0, cell_y=0; sprite_addr=200 two clk later.
// T2 pixel (239,59), kind=1 -> sprite_addr=99. Pixel (240,40) -> cell_x=1. Pixel (419,439) -> cell_x=9, cell_y=19.
// T3 score=16'h12A4, pixel (142,450) -> sprite_addr=790. Pixel (156,450), nibble A -> T_ADDR=1150, rgb=bg_data.
// T4 flash_rows[0]=1, kind=5 at (230,45): frames 0-7 -> rgb=sprite pixel; frames 8-15 -> rgb=12'hEEE; frame 16 -> sprite again.
// T5 pixel (100,60) -> bg_addr=9650. sprite_data=KEY -> rgb=bg_data. visible=0 -> rgb=0.
// T6 reset asserted mid-line -> next clk rgb=0, sprite_addr=1150; frame counter=0 after release.

Source files
------------

// File: rtl/tetris_renderer_if.sv
// tetris_renderer_if
// Bundles the pixel-pipeline signals of the tetris renderer.
//   slave  : the renderer. It takes the pixel position, cell kind, score, flash rows and SRAM data.
//            It drives the cell query, the SRAM addresses and rgb.
//   master : the environment. It covers vga_sync_reg, the playfield store, both SRAMs and the pins.
// Signals:
//   p_tick, visible, pixel_x, pixel_y : pixel timing from vga_sync_reg
//   cell_x, cell_y / cell_kind        : playfield query and answer (answer 1 clk later)
//   score, flash_rows                 : BCD score and per-row flash enables
//   sprite_addr/sprite_data           : sprite SRAM port (1 clk read latency)
//   bg_addr/bg_data                   : background SRAM port (1 clk read latency)
//   rgb                               : registered {R,G,B}
interface tetris_renderer_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BOARD_H    = 20
);
  logic                    p_tick;
  logic                    visible;
  logic [9:0]              pixel_x;
  logic [9:0]              pixel_y;
  logic [4:0]              cell_x;
  logic [4:0]              cell_y;
  logic [3:0]              cell_kind;
  logic [4*NUM_DIGITS-1:0] score;
  logic [BOARD_H-1:0]      flash_rows;
  logic [17:0]             sprite_addr;
  logic [11:0]             sprite_data;
  logic [16:0]             bg_addr;
  logic [11:0]             bg_data;
  logic [11:0]             rgb;

  modport slave (
    input  p_tick, visible, pixel_x, pixel_y, cell_kind, score, flash_rows, sprite_data, bg_data,
    output cell_x, cell_y, sprite_addr, bg_addr, rgb
  );

  modport master (
    output p_tick, visible, pixel_x, pixel_y, cell_kind, score, flash_rows, sprite_data, bg_data,
    input  cell_x, cell_y, sprite_addr, bg_addr, rgb
  );
endinterface

// File: rtl/tetris_renderer.sv
// tetris_renderer
// Three-stage pixel pipeline.
//   S1 decodes the board cell, digit region and background address.
//   S2 forms the sprite and background SRAM addresses.
//   S3 composites the SRAM data with the transparency key and the row-flash animation.
//   rgb is loaded from the S3 result on p_tick.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : tetris_renderer_if.slave (pixel timing, cell query, score, flash rows, SRAM ports, rgb)
module tetris_renderer #(
  parameter int          BOARD_X0    = 220,
  parameter int          BOARD_Y0    = 40,
  parameter int          BOARD_W     = 10,
  parameter int          BOARD_H     = 20,
  parameter int          CELL_PX     = 20,
  parameter int          SCALE       = 2,
  parameter int          NUM_DIGITS  = 4,
  parameter int          DIG_X0      = 128,
  parameter int          DIG_Y0      = 450,
  parameter int          DIG_W       = 5,
  parameter int          DIG_H       = 9,
  parameter int          DIG_GAP     = 2,
  parameter int          BG_W        = 320,
  parameter logic [11:0] KEY         = 12'hFFF,
  parameter logic [11:0] FLASH_COLOR = 12'hEEE,
  parameter int          BLINK_LOG2  = 3
) (
  input logic           clk,
  input logic           reset,
  tetris_renderer_if.slave bus
);

  localparam int S     = CELL_PX / SCALE;
  localparam int SHIFT = $clog2(SCALE);
  localparam int PITCH = (DIG_W + DIG_GAP) * SCALE;
  localparam int FW    = BLINK_LOG2 + 1;
  localparam logic [17:0]   T_ADDR    = 18'(7*S*S + 10*DIG_W*DIG_H);
  localparam logic [9:0]    BX0       = 10'(BOARD_X0);
  localparam logic [9:0]    BX1       = 10'(BOARD_X0 + BOARD_W*CELL_PX);
  localparam logic [9:0]    BY0       = 10'(BOARD_Y0);
  localparam logic [9:0]    BY1       = 10'(BOARD_Y0 + BOARD_H*CELL_PX);
  localparam logic [9:0]    DY0       = 10'(DIG_Y0);
  localparam logic [9:0]    DY1       = 10'(DIG_Y0 + DIG_H*SCALE);
  localparam logic [FW-1:0] FRAME_ONE = FW'(1);

  // S1 combinational decode
  logic        in_board_s, dig_hit_s, flash_bit_s;
  logic [9:0]  bx_s, by_s, dig_ox_s, dig_oy_s;
  logic [4:0]  col_s, row_s;
  logic [3:0]  dig_idx_s;
  logic [16:0] bg_s;
  // S1 registers
  logic        board_s1_r, dig_s1_r, vis_s1_r, flash_s1_r;
  logic [9:0]  ox_s1_r, oy_s1_r, dig_ox_s1_r, dig_oy_s1_r;
  logic [3:0]  dig_idx_s1_r;
  logic [16:0] bg_s1_r;
  // S2 combinational / registers
  logic        kind_ok_s;
  logic [3:0]  nib_s;
  logic [17:0] saddr_s;
  logic        vis_s2_r, flash_s2_r;
  // S3 registers and output mux
  logic          vis_s3_r, flash_s3_r;
  logic [11:0]   rgb_next_s;
  logic [FW-1:0] frame_r;

  // S1 region decode: board cell, digit hit and background address
  always_comb begin
    in_board_s = (bus.pixel_x >= BX0) && (bus.pixel_x < BX1) &&
                 (bus.pixel_y >= BY0) && (bus.pixel_y < BY1);
    // Offsets are only formed inside the board so the subtraction never wraps.
    if (in_board_s) begin
      bx_s = bus.pixel_x - BX0;
      by_s = bus.pixel_y - BY0;
    end else begin
      bx_s = 10'd0;
      by_s = 10'd0;
    end
    col_s       = 5'(bx_s / CELL_PX);
    row_s       = 5'(by_s / CELL_PX);
    flash_bit_s = in_board_s ? bus.flash_rows[row_s] : 1'b0;
    dig_hit_s   = 1'b0;
    dig_idx_s   = 4'd0;
    dig_ox_s    = 10'd0;
    dig_oy_s    = 10'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!dig_hit_s && (bus.pixel_y >= DY0) && (bus.pixel_y < DY1) &&
          (int'(bus.pixel_x) >= DIG_X0 + i*PITCH) &&
          (int'(bus.pixel_x) <  DIG_X0 + i*PITCH + DIG_W*SCALE)) begin
        dig_hit_s = 1'b1;
        dig_idx_s = 4'(i);
        dig_ox_s  = 10'(int'(bus.pixel_x) - DIG_X0 - i*PITCH);
        dig_oy_s  = bus.pixel_y - DY0;
      end else begin
        dig_hit_s = dig_hit_s;
      end
    end
    bg_s = 17'(int'(bus.pixel_y >> SHIFT) * BG_W + int'(bus.pixel_x >> SHIFT));
  end

  // S1 registers: cell query outputs, offsets and region flags
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.cell_x   <= 5'd0;
      bus.cell_y   <= 5'd0;
      ox_s1_r      <= 10'd0;
      oy_s1_r      <= 10'd0;
      board_s1_r   <= 1'b0;
      dig_s1_r     <= 1'b0;
      dig_idx_s1_r <= 4'd0;
      dig_ox_s1_r  <= 10'd0;
      dig_oy_s1_r  <= 10'd0;
      vis_s1_r     <= 1'b0;
      flash_s1_r   <= 1'b0;
      bg_s1_r      <= 17'd0;
    end else begin
      bus.cell_x   <= col_s;
      bus.cell_y   <= row_s;
      ox_s1_r      <= 10'(bx_s % CELL_PX);
      oy_s1_r      <= 10'(by_s % CELL_PX);
      board_s1_r   <= in_board_s;
      dig_s1_r     <= dig_hit_s;
      dig_idx_s1_r <= dig_idx_s;
      dig_ox_s1_r  <= dig_ox_s;
      dig_oy_s1_r  <= dig_oy_s;
      vis_s1_r     <= bus.visible;
      flash_s1_r   <= flash_bit_s;
      bg_s1_r      <= bg_s;
    end
  end

  // S2 sprite address: the board wins over digits; a blank or invalid entry points at the KEY word
  always_comb begin
    kind_ok_s = (bus.cell_kind >= 4'd1) && (bus.cell_kind <= 4'd7);
    nib_s     = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx_s1_r == 4'(i)) begin
        nib_s = bus.score[4*(NUM_DIGITS-1-i) +: 4];
      end else begin
        nib_s = nib_s;
      end
    end
    if (board_s1_r) begin
      if (kind_ok_s) begin
        saddr_s = 18'((int'(bus.cell_kind) - 1)*S*S +
                      int'(oy_s1_r >> SHIFT)*S + int'(ox_s1_r >> SHIFT));
      end else begin
        saddr_s = T_ADDR;
      end
    end else if (dig_s1_r) begin
      if (nib_s <= 4'd9) begin
        saddr_s = 18'(7*S*S + int'(nib_s)*DIG_W*DIG_H +
                      int'(dig_oy_s1_r >> SHIFT)*DIG_W + int'(dig_ox_s1_r >> SHIFT));
      end else begin
        saddr_s = T_ADDR;
      end
    end else begin
      saddr_s = T_ADDR;
    end
  end

  // S2 registers: SRAM addresses plus delayed visible/flash qualifiers
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sprite_addr <= T_ADDR;
      bus.bg_addr     <= 17'd0;
      vis_s2_r        <= 1'b0;
      flash_s2_r      <= 1'b0;
    end else begin
      bus.sprite_addr <= saddr_s;
      bus.bg_addr     <= bg_s1_r;
      vis_s2_r        <= vis_s1_r;
      flash_s2_r      <= flash_s1_r && board_s1_r && kind_ok_s;
    end
  end

  // S3 registers: qualifiers aligned with the SRAM read data
  always_ff @(posedge clk) begin
    if (reset) begin
      vis_s3_r   <= 1'b0;
      flash_s3_r <= 1'b0;
    end else begin
      vis_s3_r   <= vis_s2_r;
      flash_s3_r <= flash_s2_r;
    end
  end

  // Frame counter: advances once per frame at the (0,0) pixel; its MSB is the flash phase
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_r <= '0;
    end else if (bus.p_tick && (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0)) begin
      frame_r <= frame_r + FRAME_ONE;
    end else begin
      frame_r <= frame_r;
    end
  end

  // S3 compositing: blanking, then flash, then opaque sprite, then background
  always_comb begin
    if (!vis_s3_r) begin
      rgb_next_s = 12'h000;
    end else if (flash_s3_r && frame_r[BLINK_LOG2]) begin
      rgb_next_s = FLASH_COLOR;
    end else if (bus.sprite_data != KEY) begin
      rgb_next_s = bus.sprite_data;
    end else begin
      rgb_next_s = bus.bg_data;
    end
  end

  // Output register: rgb follows the pixel strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rgb <= 12'h000;
    end else if (bus.p_tick) begin
      bus.rgb <= rgb_next_s;
    end else begin
      bus.rgb <= bus.rgb;
    end
  end

endmodule

// File: tb/tb_tetris_renderer.sv
// tb_tetris_renderer
// Directed bench for tetris_renderer with default parameters.
// Each pixel occupies a 4-clk slot with p_tick in the last cycle.
// A spec-level model computes the cell query, the SRAM addresses and the final colour.
// Literal expectations from the worked examples pin that model.
// The bench contains small SRAM models that return data 1 clk after the address.
module tb_tetris_renderer;
  logic clk;
  logic reset;
  logic [15:0] score_v;
  logic [19:0] flash_v;
  int checks;
  int failures;
  int model_frame;
  int prev_rgb;

  tetris_renderer_if #(.NUM_DIGITS(4), .BOARD_H(20)) bus ();

  tetris_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.score      = score_v;
  assign bus.flash_rows = flash_v;

  always #5 clk = ~clk;

  function automatic logic [11:0] spr_mem(input logic [17:0] a);
    return (a == 18'd1150) ? 12'hFFF : (a[11:0] ^ 12'h5A5);
  endfunction

  function automatic logic [11:0] bg_mem(input logic [16:0] a);
    return a[11:0] ^ 12'h3C3;
  endfunction

  always @(posedge clk) begin
    bus.sprite_data <= spr_mem(bus.sprite_addr);
    bus.bg_data     <= bg_mem(bus.bg_addr);
  end

  // ---------------- model ----------------
  function automatic bit m_board(input int x, input int y);
    return (x >= 220) && (x < 420) && (y >= 40) && (y < 440);
  endfunction

  function automatic int m_cx(input int x, input int y);
    return m_board(x, y) ? (x - 220) / 20 : 0;
  endfunction

  function automatic int m_cy(input int x, input int y);
    return m_board(x, y) ? (y - 40) / 20 : 0;
  endfunction

  function automatic int m_bg(input int x, input int y);
    return (y / 2) * 320 + x / 2;
  endfunction

  function automatic int m_sprite(input int x, input int y, input int kind);
    int lo;
    int d;
    if (m_board(x, y)) begin
      if (kind >= 1 && kind <= 7)
        return (kind - 1) * 100 + (((y - 40) % 20) / 2) * 10 + ((x - 220) % 20) / 2;
      return 1150;
    end
    for (int i = 0; i < 4; i++) begin
      lo = 128 + 14 * i;
      if (x >= lo && x < lo + 10 && y >= 450 && y < 468) begin
        d = (int'(score_v) >> (4 * (3 - i))) & 15;
        if (d <= 9) return 700 + 45 * d + ((y - 450) / 2) * 5 + (x - lo) / 2;
        return 1150;
      end
    end
    return 1150;
  endfunction

  function automatic int m_rgb(input int x, input int y, input bit vis, input int kind);
    logic [11:0] sd;
    if (!vis) return 0;
    if (m_board(x, y) && flash_v[(y - 40) / 20] && model_frame >= 8 && kind >= 1 && kind <= 7)
      return 'hEEE;
    sd = spr_mem(18'(m_sprite(x, y, kind)));
    if (sd != 12'hFFF) return int'(sd);
    return int'(bg_mem(17'(m_bg(x, y))));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One pixel slot; a literal argument of -1 means "no literal for this one".
  task automatic slot(input int x, input int y, input bit vis, input int kind,
                      input int lit_cx, input int lit_cy, input int lit_sa,
                      input int lit_bg, input int lit_rgb);
    int exp_rgb;
    bus.pixel_x   = 10'(x);
    bus.pixel_y   = 10'(y);
    bus.visible   = vis;
    bus.cell_kind = 4'(kind);
    bus.p_tick    = 1'b0;
    exp_rgb = m_rgb(x, y, vis, kind);
    @(negedge clk);
    chk("cell_x", int'(bus.cell_x), m_cx(x, y));
    chk("cell_y", int'(bus.cell_y), m_cy(x, y));
    if (lit_cx >= 0) chk("cell_x_lit", int'(bus.cell_x), lit_cx);
    if (lit_cy >= 0) chk("cell_y_lit", int'(bus.cell_y), lit_cy);
    @(negedge clk);
    chk("sprite_addr", int'(bus.sprite_addr), m_sprite(x, y, kind));
    chk("bg_addr", int'(bus.bg_addr), m_bg(x, y));
    if (lit_sa >= 0) chk("sprite_addr_lit", int'(bus.sprite_addr), lit_sa);
    if (lit_bg >= 0) chk("bg_addr_lit", int'(bus.bg_addr), lit_bg);
    @(negedge clk);
    chk("rgb_hold", int'(bus.rgb), prev_rgb);
    bus.p_tick = 1'b1;
    @(negedge clk);
    bus.p_tick = 1'b0;
    chk("rgb", int'(bus.rgb), exp_rgb);
    if (lit_rgb >= 0) chk("rgb_lit", int'(bus.rgb), lit_rgb);
    prev_rgb = exp_rgb;
    if (x == 0 && y == 0) model_frame = (model_frame + 1) % 16;
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    checks = 0;
    failures = 0;
    model_frame = 0;
    prev_rgb = 0;
    score_v = 16'h0000;
    flash_v = 20'h00000;
    bus.p_tick = 1'b0;
    bus.visible = 1'b0;
    bus.pixel_x = 10'd0;
    bus.pixel_y = 10'd0;
    bus.cell_kind = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_rgb", int'(bus.rgb), 0);
    chk("reset_sprite_addr", int'(bus.sprite_addr), 1150);
    chk("reset_bg_addr", int'(bus.bg_addr), 0);
    chk("reset_cell_x", int'(bus.cell_x), 0);
    chk("reset_cell_y", int'(bus.cell_y), 0);
    reset = 1'b0;

    // Board cells and edges
    slot(220, 40, 1'b1, 3, 0, 0, 200, -1, -1);
    slot(239, 59, 1'b1, 1, -1, -1, 99, -1, -1);
    slot(240, 40, 1'b1, 2, 1, 0, -1, -1, -1);
    slot(419, 439, 1'b1, 7, 9, 19, -1, -1, -1);
    slot(300, 100, 1'b1, 0, -1, -1, 1150, -1, -1);
    slot(300, 100, 1'b1, 9, -1, -1, 1150, -1, -1);
    slot(420, 40, 1'b1, 4, 0, 0, 1150, -1, -1);
    slot(219, 439, 1'b1, 4, 0, 0, 1150, -1, -1);

    // Score digits
    score_v = 16'h12A4;
    slot(142, 450, 1'b1, 0, -1, -1, 790, -1, -1);
    slot(156, 450, 1'b1, 0, -1, -1, 1150, -1, int'(bg_mem(17'(225*320 + 78))));
    slot(128, 450, 1'b1, 0, -1, -1, 745, -1, -1);
    slot(173, 455, 1'b1, 0, -1, -1, 891, -1, -1);
    slot(179, 467, 1'b1, 0, -1, -1, -1, -1, -1);
    slot(138, 450, 1'b1, 0, -1, -1, 1150, -1, -1);

    // Background, key transparency and blanking
    slot(100, 60, 1'b1, 0, 0, 0, 1150, 9650, int'(bg_mem(17'd9650)));
    slot(100, 60, 1'b0, 0, -1, -1, -1, 9650, 0);

    // Row flash over 17 frames
    flash_v = 20'h00001;
    for (int f = 0; f <= 16; f++) begin
      slot(230, 45, 1'b1, 5, -1, -1, 425, -1, (f >= 8 && f <= 15) ? 'hEEE : 'h40C);
      slot(0, 0, 1'b1, 0, -1, -1, -1, -1, -1);
    end
    slot(230, 65, 1'b1, 5, -1, 1, -1, -1, -1);
    slot(230, 45, 1'b1, 0, -1, -1, 1150, -1, -1);

    // Mid-line reset while flashing
    repeat (8) slot(0, 0, 1'b1, 0, -1, -1, -1, -1, -1);
    slot(230, 45, 1'b1, 5, -1, -1, -1, -1, 'hEEE);
    bus.pixel_x = 10'd300;
    bus.pixel_y = 10'd100;
    bus.cell_kind = 4'd2;
    bus.visible = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_rgb", int'(bus.rgb), 0);
    chk("midreset_sprite_addr", int'(bus.sprite_addr), 1150);
    chk("midreset_cell_x", int'(bus.cell_x), 0);
    reset = 1'b0;
    model_frame = 0;
    prev_rgb = 0;
    slot(230, 45, 1'b1, 5, -1, -1, 425, -1, 'h40C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
